clkgate_ctrl: RTL
=================

// Module: clkgate_ctrl
// PURPOSE
//  Clock-gating controller that shares one gated clock branch among NREQ requesters.
//  It drives the enable of the downstream ICG / clkinv tree and wakes the branch on demand.
//  It grants requesters only after a settle delay, and gates the branch off after an idle timeout.
//  It sits in the always-on CLK domain, beside the gated clock-buffer/inverter tree it controls.
// PARAMETERS
//  NREQ      4   number of requesters (1..16)
//  WAKE_CYC  2   cycles clk_en must be high before any ack is given (>=1)
//  IDLE_CYC  8   consecutive request-free cycles before clk_en drops (>=1)
//  CNT_W     4   timer width; must hold max(WAKE_CYC,IDLE_CYC)-1 (elaboration check)
// PORTS
//  CLK       in   1      free-running always-on clock
//  RST       in   1      asynchronous, active-high reset
//  req       in   NREQ   per-requester level request; held high while the clock is needed
//  ack       out  NREQ   per-requester grant; high = gated clock guaranteed running
//  clk_en    out  1      enable to the downstream clock gate
//  busy      out  1      state != OFF
//  wake_cnt  out  16     number of OFF->WAKE transitions (only with CLKGATE_CTRL_STATS_EN)
// BEHAVIOUR
//  Reset values: clk_en=0, ack=0, busy=0, state=OFF, timer=0, wake_cnt=0.
//  Reset is one clock domain, asynchronous and active-high; assertion at any time forces these values.
//  All outputs are registered. There is no combinational path from req to any output.
//  FSM transitions:
//   OFF : clk_en=0. If |req, go to WAKE and load the timer with WAKE_CYC-1.
//   WAKE: clk_en=1. The timer decrements each cycle. When timer==0:
//         go to ON if |req, otherwise go to IDLE and load IDLE_CYC-1.
//         WAKE is never aborted: req dropping during WAKE does not end it early (no runt enable pulse).
//   ON  : clk_en=1. If req==0, go to IDLE and load IDLE_CYC-1.
//   IDLE: clk_en=1; the timer decrements.
//         If |req, return to ON; any req inside IDLE cancels the countdown.
//         If the timer reaches 0 with no req, go to OFF; clk_en falls on that same edge.
//  Ack rule: ack <= req & {NREQ{next_state==ON}}.
//   - Latency from req rising while OFF to ack: WAKE_CYC+1 edges.
//   - Latency while ON/IDLE: 1 edge.
//   - ack falls 1 edge after its req falls.
//  Invariant: ack != 0 implies clk_en == 1. ack never rises in OFF or WAKE.
//  Simultaneous events:
//   - Multiple req bits are all granted together; there is no priority, since the clock is a shared resource.
//   - req rising on the same edge the IDLE timer hits 0 takes ON; gating off loses the tie.
//  Timer arithmetic: CNT_W-bit unsigned down-counter; it never wraps (loads happen only on state entry).
// CONFIGURATION
//  CLKGATE_CTRL_STATS_EN defined:
//   - wake_cnt port is present.
//   - It increments on each OFF->WAKE edge and saturates at 16'hFFFF.
//  CLKGATE_CTRL_STATS_EN undefined:
//   - wake_cnt port and counter are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  Package clkgate_ctrl_pkg holds:
//   - typedef enum logic [1:0] state_t {ST_OFF=2'd0, ST_WAKE=2'd1, ST_ON=2'd2, ST_IDLE=2'd3}
//   - localparam WAKE_CNT_W = 16
//  Sub-module clkgate_ctrl_timer:
//   - Load/decrement counter with a zero flag.
//   - One instance is shared by WAKE and IDLE.
//  FSM, ack register and stats counter live in clkgate_ctrl.
// TESTING  (NREQ=4, WAKE_CYC=2, IDLE_CYC=8)
//  1. Cold wake:
//     - Stimulus: RST pulse, then req=4'b0001 at edge 0.
//     - Response: clk_en=1 at edge 1, ack=4'b0001 at edge 3, busy=1.
//  2. Idle timeout:
//     - Stimulus: from ON, drop req at edge 10.
//     - Response: ack=0 at edge 11, clk_en=0 at edge 19, busy=0.
//  3. Idle rescue:
//     - Stimulus: in IDLE, assert req=4'b0100 on the cycle the timer==0.
//     - Response: state ON, ack=4'b0100 next edge, clk_en never drops.
//  4. Drop during WAKE:
//     - Stimulus: req pulse of 1 cycle while OFF.
//     - Response: clk_en high for exactly WAKE_CYC+IDLE_CYC=10 cycles, ack stays 0.
//  5. Multi-requester:
//     - Stimulus: req=4'b1010 in ON, then req=4'b1000.
//     - Response: ack follows with 1-edge lag, clk_en stays 1.
//  6. Reset mid-ON:
//     - Stimulus: RST asserted between edges.
//     - Response: clk_en=0 and ack=0 immediately (before next CLK).
//     - With CLKGATE_CTRL_STATS_EN: wake_cnt=0.
//     - Stats only: 3 wakes give wake_cnt=3.

Source files
------------

// File: rtl/clkgate_ctrl_pkg.sv
// Purpose: shared types and constants for the clock-gating controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clkgate_ctrl_pkg;

    // Controller states. The encoding is visible to anyone probing the branch,
    // so it is fixed rather than left to the tool.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    // Width of the OFF->WAKE event counter (present only in stats builds).
    localparam int WAKE_CNT_W = 16;

endpackage

// File: rtl/clkgate_ctrl_timer.sv
// Purpose: load/decrement down-counter with a zero flag, shared by WAKE and IDLE.
// Latency: load and decrement take effect on the next CLK edge; zero reflects the current count.
// Backpressure: none; the counter stops at zero instead of wrapping.
//
// Ports:
//   CLK      in  1      always-on clock
//   RST      in  1      asynchronous active-high reset (count -> 0)
//   load     in  1      load load_val (wins over dec)
//   load_val in  CNT_W  value to load
//   dec      in  1      decrement by one if non-zero
//   zero     out 1      count == 0
module clkgate_ctrl_timer #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clkgate_ctrl.sv
// Purpose: clock-gating controller sharing one gated clock branch among NREQ requesters.
// Latency: ack WAKE_CYC+1 edges after req from OFF, 1 edge from ON/IDLE; clk_en drops IDLE_CYC edges after last req.
// Backpressure: none; level req/ack handshake, ack only while the gated clock is guaranteed running.
//
// Ports:
//   CLK       in  1           free-running always-on clock
//   RST       in  1           asynchronous active-high reset
//   req       in  NREQ        per-requester level request
//   ack       out NREQ        per-requester grant (gated clock running)
//   clk_en    out 1           enable to the downstream clock gate
//   busy      out 1           controller is not OFF
//   wake_cnt  out WAKE_CNT_W  saturating OFF->WAKE count (CLKGATE_CTRL_STATS_EN only)
//
// Build option: define CLKGATE_CTRL_STATS_EN to add the wake_cnt port and counter.
module clkgate_ctrl
    import clkgate_ctrl_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       ack,
    output logic                  clk_en,
    output logic                  busy
`ifdef CLKGATE_CTRL_STATS_EN
    ,
    output logic [WAKE_CNT_W-1:0] wake_cnt
`endif
);

    // Parameter sanity: the timer must be able to hold both load values.
    if ((NREQ < 1) || (NREQ > 16) || (WAKE_CYC < 1) || (IDLE_CYC < 1) || (CNT_W < 1) ||
        ((WAKE_CYC - 1) >= (1 << CNT_W)) || ((IDLE_CYC - 1) >= (1 << CNT_W))) begin : g_bad_params
        $error("clkgate_ctrl: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic             req_any;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    assign req_any = |req;

    clkgate_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state and timer control. The timer is only loaded on state entry,
    // so a single counter serves both the settle delay and the idle timeout.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        case (state)
            ST_OFF: begin
                if (req_any) begin
                    next_state = ST_WAKE;
                    tmr_load   = 1'b1;
                    tmr_val    = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Runs to completion regardless of req so the enable never glitches.
                if (tmr_zero) begin
                    if (req_any) begin
                        next_state = ST_ON;
                    end else begin
                        next_state = ST_IDLE;
                        tmr_load   = 1'b1;
                        tmr_val    = IDLE_LOAD;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ON: begin
                if (!req_any) begin
                    next_state = ST_IDLE;
                    tmr_load   = 1'b1;
                    tmr_val    = IDLE_LOAD;
                end
            end
            ST_IDLE: begin
                // A request wins the tie against the timeout expiring.
                if (req_any) begin
                    next_state = ST_ON;
                end else if (tmr_zero) begin
                    next_state = ST_OFF;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                next_state = ST_OFF;
            end
        endcase
    end

    // Outputs are registered from next_state so they change on the same edge
    // as the state itself, with no combinational path from req.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_OFF;
            clk_en <= 1'b0;
            busy   <= 1'b0;
            ack    <= '0;
        end else begin
            state  <= next_state;
            clk_en <= (next_state != ST_OFF);
            busy   <= (next_state != ST_OFF);
            ack    <= req & {NREQ{next_state == ST_ON}};
        end
    end

`ifdef CLKGATE_CTRL_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wake_cnt <= '0;
        end else if ((state == ST_OFF) && (next_state == ST_WAKE) && (wake_cnt != '1)) begin
            wake_cnt <= wake_cnt + 1'b1;
        end
    end
`endif

endmodule
